// File: rtl/pipeline_stall_pkg.sv
// Shared types and default constants for the pipeline stall controller.
package pipeline_stall_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        GRANT  = 2'd2,
        HALT   = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [5:0] DEF_OP_HLT     = 6'b010001;
    localparam logic [5:0] DEF_OP_LOAD    = 6'b010100;
    localparam logic [5:0] DEF_JUMP_MASK  = 6'b111100;
    localparam logic [5:0] DEF_JUMP_MATCH = 6'b011100;

endpackage

// File: rtl/stall_bubble_counter.sv
// Loadable down-counter holding the remaining bubble cycles; stops at zero.
module stall_bubble_counter
    import pipeline_stall_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall controller for the ID stage: bubbles on jumps/loads, hold on halt.
// Optional STALL_STATS_EN adds stall_cycles and halt_seen statistics outputs.
//
// state  | meaning
// RUN    | decode op in ID; stall on first bubble cycle or halt
// BUBBLE | remaining bubble cycles, op ignored
// GRANT  | one unstalled cycle so the held instruction advances
// HALT   | frozen until resume
module pipeline_stall_ctrl #(
    parameter int              OP_W         = 6,
    parameter int              JUMP_BUBBLES = 2,
    parameter int              LOAD_BUBBLES = 1,
    parameter logic [OP_W-1:0] OP_HLT       = OP_W'(pipeline_stall_pkg::DEF_OP_HLT),
    parameter logic [OP_W-1:0] OP_LOAD      = OP_W'(pipeline_stall_pkg::DEF_OP_LOAD),
    parameter logic [OP_W-1:0] JUMP_MASK    = OP_W'(pipeline_stall_pkg::DEF_JUMP_MASK),
    parameter logic [OP_W-1:0] JUMP_MATCH   = OP_W'(pipeline_stall_pkg::DEF_JUMP_MATCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            resume,
    output logic            stall,
    output logic            stall_pm,
`ifdef STALL_STATS_EN
    output logic [15:0]     stall_cycles,
    output logic            halt_seen,
`endif
    output logic            halted
);

    import pipeline_stall_pkg::*;

    localparam int MAX_BUBBLES = (1 << CNT_W) - 1;

    if (JUMP_BUBBLES < 0 || JUMP_BUBBLES > MAX_BUBBLES ||
        LOAD_BUBBLES < 0 || LOAD_BUBBLES > MAX_BUBBLES) begin : g_bad_bubbles
        $error("pipeline_stall_ctrl: bubble parameters must be in 0..15");
    end

    localparam bit JUMP_EN = (JUMP_BUBBLES >= 1);
    localparam bit LOAD_EN = (LOAD_BUBBLES >= 1);
    localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_EN ? JUMP_BUBBLES - 1 : 0);
    localparam logic [CNT_W-1:0] LOAD_LOAD = CNT_W'(LOAD_EN ? LOAD_BUBBLES - 1 : 0);
    localparam state_t JUMP_NEXT = (JUMP_BUBBLES > 1) ? BUBBLE : GRANT;
    localparam state_t LOAD_NEXT = (LOAD_BUBBLES > 1) ? BUBBLE : GRANT;

    state_t             state_q;
    state_t             state_d;
    logic               is_hlt;
    logic               is_jmp;
    logic               is_ld;
    logic               stall_raw;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_zero;

    assign is_hlt = (op == OP_HLT);
    assign is_jmp = ((op & JUMP_MASK) == JUMP_MATCH);
    assign is_ld  = (op == OP_LOAD);

    stall_bubble_counter #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        stall_raw    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            RUN: begin
                if (is_hlt) begin
                    stall_raw = 1'b1;
                    state_d   = HALT;
                end else if (is_jmp && JUMP_EN) begin
                    stall_raw    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = JUMP_LOAD;
                    state_d      = JUMP_NEXT;
                end else if (is_ld && LOAD_EN) begin
                    stall_raw    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_LOAD;
                    state_d      = LOAD_NEXT;
                end
            end
            BUBBLE: begin
                // The count is the bubbles left including this one; leave after the last.
                stall_raw = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt_zero || cnt == CNT_W'(1)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = RUN;
            end
            HALT: begin
                stall_raw = 1'b1;
                if (resume) begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall = stall_raw & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            stall_pm <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stall_pm <= stall;
            halted   <= (state_d == HALT);
        end
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            halt_seen    <= 1'b0;
        end else begin
            if (stall && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (state_d == HALT) begin
                halt_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default, 4-jump-bubble and 0-load-bubble builds.
module tb_pipeline_stall_ctrl;

    localparam logic [5:0] OP_JMP = 6'b011101;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_HL  = 6'b010001;
    localparam logic [5:0] OP_ADD = 6'b000000;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rst_c;
    logic [5:0] op_a, op_b, op_c;
    logic       res_a, res_b, res_c;
    logic       stall_a, stall_b, stall_c;
    logic       pm_a, pm_b, pm_c;
    logic       halt_a, halt_b, halt_c;
`ifdef STALL_STATS_EN
    logic [15:0] sc_a, sc_b, sc_c;
    logic        hs_a, hs_b, hs_c;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut_a (
        .clk(clk), .reset(rst_a), .op(op_a), .resume(res_a),
        .stall(stall_a), .stall_pm(pm_a),
`ifdef STALL_STATS_EN
        .stall_cycles(sc_a), .halt_seen(hs_a),
`endif
        .halted(halt_a)
    );

    pipeline_stall_ctrl #(.JUMP_BUBBLES(4)) dut_b (
        .clk(clk), .reset(rst_b), .op(op_b), .resume(res_b),
        .stall(stall_b), .stall_pm(pm_b),
`ifdef STALL_STATS_EN
        .stall_cycles(sc_b), .halt_seen(hs_b),
`endif
        .halted(halt_b)
    );

    pipeline_stall_ctrl #(.LOAD_BUBBLES(0)) dut_c (
        .clk(clk), .reset(rst_c), .op(op_c), .resume(res_c),
        .stall(stall_c), .stall_pm(pm_c),
`ifdef STALL_STATS_EN
        .stall_cycles(sc_c), .halt_seen(hs_c),
`endif
        .halted(halt_c)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        op_a = OP_ADD; op_b = OP_ADD; op_c = OP_ADD;
        res_a = 1'b0; res_b = 1'b0; res_c = 1'b0;
        cyc(); cyc();

        // Reset state; a jump op during reset must not stall
        op_a = OP_JMP; #3;
        chk("rst_stall", stall_a, 0);
        chk("rst_pm", pm_a, 0);
        chk("rst_halted", halt_a, 0);
`ifdef STALL_STATS_EN
        chk("rst_sc", sc_a, 0);
        chk("rst_hs", hs_a, 0);
`endif

        // Jump, 2 bubbles
        cyc(); rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; #3;
        chk("jmp_c0_stall", stall_a, 1);
        chk("jmp_c0_pm", pm_a, 0);
        cyc(); #3;
        chk("jmp_c1_stall", stall_a, 1);
        chk("jmp_c1_pm", pm_a, 1);
        cyc(); #3;
        chk("jmp_c2_stall", stall_a, 0);
        chk("jmp_c2_pm", pm_a, 1);
        cyc(); op_a = OP_ADD; #3;
        chk("jmp_c3_stall", stall_a, 0);
        chk("jmp_c3_pm", pm_a, 0);
`ifdef STALL_STATS_EN
        chk("jmp_sc", sc_a, 2);
        chk("jmp_hs", hs_a, 0);
`endif

        // Load then add
        cyc(); op_a = OP_LD; #3;
        chk("ld_c0_stall", stall_a, 1);
        cyc(); #3;
        chk("ld_c1_grant_stall", stall_a, 0);
        chk("ld_c1_pm", pm_a, 1);
        cyc(); op_a = OP_ADD; #3;
        chk("ld_c2_stall", stall_a, 0);
        chk("ld_c2_pm", pm_a, 0);

        // Back-to-back: load, GRANT (next op is a jump), jump evaluated in RUN
        cyc(); op_a = OP_LD; #3;
        chk("b2b_ld_stall", stall_a, 1);
        cyc(); op_a = OP_JMP; #3;
        chk("b2b_grant_stall", stall_a, 0);
        cyc(); #3;
        chk("b2b_jmp_c0", stall_a, 1);
        cyc(); #3;
        chk("b2b_jmp_c1", stall_a, 1);
        cyc(); #3;
        chk("b2b_jmp_grant", stall_a, 0);
        cyc(); op_a = OP_ADD; #3;
        chk("b2b_add", stall_a, 0);

        // Halt; resume in the detection cycle is ignored
        cyc(); op_a = OP_HL; res_a = 1'b1; #3;
        chk("hlt_c0_stall", stall_a, 1);
        chk("hlt_c0_halted", halt_a, 0);
        cyc(); res_a = 1'b0; #3;
        chk("hlt_c1_stall", stall_a, 1);
        chk("hlt_c1_halted", halt_a, 1);
        for (int i = 2; i <= 4; i++) begin
            cyc(); #3;
            chk("hlt_mid_halted", halt_a, 1);
            chk("hlt_mid_stall", stall_a, 1);
        end
        cyc(); res_a = 1'b1; #3;
        chk("hlt_c5_stall", stall_a, 1);
        chk("hlt_c5_halted", halt_a, 1);
        cyc(); res_a = 1'b0; #3;
        chk("hlt_c6_stall", stall_a, 0);
        chk("hlt_c6_halted", halt_a, 0);
        chk("hlt_c6_pm", pm_a, 1);
        cyc(); op_a = OP_ADD; #3;
        chk("hlt_c7_stall", stall_a, 0);
        chk("hlt_c7_pm", pm_a, 0);
`ifdef STALL_STATS_EN
        chk("hlt_sc", sc_a, 12);
        chk("hlt_hs", hs_a, 1);
`endif

        // Reset while in HALT
        cyc(); op_a = OP_HL; #3;
        chk("rh_c0_stall", stall_a, 1);
        cyc(); #3;
        chk("rh_c1_halted", halt_a, 1);
        cyc(); rst_a = 1'b1; #3;
        chk("rh_rst_stall", stall_a, 0);
        cyc(); rst_a = 1'b0; op_a = OP_ADD; #3;
        chk("rh_after_stall", stall_a, 0);
        chk("rh_after_halted", halt_a, 0);
        chk("rh_after_pm", pm_a, 0);
`ifdef STALL_STATS_EN
        chk("rh_sc", sc_a, 0);
        chk("rh_hs", hs_a, 0);
`endif

        // JUMP_BUBBLES=4, reset at the 2nd bubble cycle
        cyc(); op_b = OP_JMP; #3;
        chk("j4_c0_stall", stall_b, 1);
        cyc(); #3;
        chk("j4_c1_stall", stall_b, 1);
        cyc(); rst_b = 1'b1; #3;
        chk("j4_rst_stall", stall_b, 0);
        cyc(); rst_b = 1'b0; #3;
        chk("j4_re_c0_stall", stall_b, 1);
        chk("j4_re_c0_pm", pm_b, 0);
        chk("j4_re_c0_halted", halt_b, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(); #3;
            chk("j4_re_bubble", stall_b, 1);
        end
        cyc(); #3;
        chk("j4_grant_stall", stall_b, 0);
        chk("j4_grant_pm", pm_b, 1);
        cyc(); op_b = OP_ADD; #3;
        chk("j4_add_stall", stall_b, 0);

        // LOAD_BUBBLES=0: loads never stall
        for (int i = 0; i < 3; i++) begin
            cyc(); op_c = OP_LD; #3;
            chk("ld0_stall", stall_c, 0);
            chk("ld0_pm", pm_c, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
